// File: rtl/match_referee.sv
// Best-of-N match controller: re-arms the downstream counter each round and scores its results.
// Optional PLAY watchdog enabled by defining REFEREE_TIMEOUT_EN.
module match_referee #(
   parameter int ROUNDS_TO_WIN  = 3,
   parameter int HOLD_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic [3:0] seed_i,
   input  logic       gameover_i,
   input  logic [1:0] who_i,
   output logic       cnt_rst_n_o,
   output logic       init_o,
   output logic [3:0] load_val_o,
   output logic [3:0] score_w_o,
   output logic [3:0] score_l_o,
   output logic [3:0] round_o,
   output logic       match_done_o,
   output logic [1:0] champion_o
);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_LOAD, S_PLAY, S_DONE} state_t;

   localparam logic [3:0] WIN_SCORE = 4'(ROUNDS_TO_WIN);
   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] hold_q, hold_d;
   logic       cnt_rst_n_q, cnt_rst_n_d;
   logic       init_q, init_d;
   logic [3:0] load_val_q, load_val_d;
   logic [3:0] score_w_q, score_w_d;
   logic [3:0] score_l_q, score_l_d;
   logic [3:0] round_q, round_d;
   logic       match_done_q, match_done_d;
   logic [1:0] champion_q, champion_d;
   logic [3:0] round_inc;
   logic [3:0] score_w_inc;
   logic [3:0] score_l_inc;

`ifdef REFEREE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] play_cnt_q, play_cnt_d;
`endif

   assign round_inc   = (round_q == 4'hF) ? 4'hF : round_q + 4'd1;
   assign score_w_inc = score_w_q + 4'd1;
   assign score_l_inc = score_l_q + 4'd1;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      cnt_rst_n_d  = cnt_rst_n_q;
      init_d       = 1'b0;
      load_val_d   = load_val_q;
      score_w_d    = score_w_q;
      score_l_d    = score_l_q;
      round_d      = round_q;
      match_done_d = match_done_q;
      champion_d   = champion_q;
`ifdef REFEREE_TIMEOUT_EN
      play_cnt_d   = '0;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            cnt_rst_n_d = 1'b0;
            if (start_i) begin
               state_d      = S_ARM;
               hold_d       = 4'd0;
               score_w_d    = 4'd0;
               score_l_d    = 4'd0;
               round_d      = 4'd0;
               match_done_d = 1'b0;
               champion_d   = 2'b00;
            end
         end
         S_ARM: begin
            cnt_rst_n_d = 1'b0;
            if (hold_q == HOLD_LAST) begin
               state_d     = S_LOAD;
               hold_d      = 4'd0;
               cnt_rst_n_d = 1'b1;
               init_d      = 1'b1;
               load_val_d  = seed_i;
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         S_LOAD: begin
            state_d     = S_PLAY;
            cnt_rst_n_d = 1'b1;
         end
         S_PLAY: begin
            cnt_rst_n_d = 1'b1;
            if (gameover_i) begin
               round_d     = round_inc;
               state_d     = S_ARM;
               hold_d      = 4'd0;
               cnt_rst_n_d = 1'b0;
               if (who_i == 2'b01) score_w_d = score_w_inc;
               if (who_i == 2'b10) score_l_d = score_l_inc;
               // A round that reaches the target ends the match instead of re-arming.
               if ((who_i == 2'b01 && score_w_inc == WIN_SCORE) ||
                   (who_i == 2'b10 && score_l_inc == WIN_SCORE)) begin
                  state_d      = S_DONE;
                  match_done_d = 1'b1;
                  champion_d   = who_i;
               end
            end
`ifdef REFEREE_TIMEOUT_EN
            else if (play_cnt_q == TIMEOUT_LAST) begin
               round_d     = round_inc;
               state_d     = S_ARM;
               hold_d      = 4'd0;
               cnt_rst_n_d = 1'b0;
            end else begin
               play_cnt_d = play_cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d     = S_IDLE;
            cnt_rst_n_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         hold_q       <= 4'd0;
         cnt_rst_n_q  <= 1'b0;
         init_q       <= 1'b0;
         load_val_q   <= 4'd0;
         score_w_q    <= 4'd0;
         score_l_q    <= 4'd0;
         round_q      <= 4'd0;
         match_done_q <= 1'b0;
         champion_q   <= 2'b00;
`ifdef REFEREE_TIMEOUT_EN
         play_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cnt_rst_n_q  <= cnt_rst_n_d;
         init_q       <= init_d;
         load_val_q   <= load_val_d;
         score_w_q    <= score_w_d;
         score_l_q    <= score_l_d;
         round_q      <= round_d;
         match_done_q <= match_done_d;
         champion_q   <= champion_d;
`ifdef REFEREE_TIMEOUT_EN
         play_cnt_q   <= play_cnt_d;
`endif
      end
   end

   assign cnt_rst_n_o  = cnt_rst_n_q;
   assign init_o       = init_q;
   assign load_val_o   = load_val_q;
   assign score_w_o    = score_w_q;
   assign score_l_o    = score_l_q;
   assign round_o      = round_q;
   assign match_done_o = match_done_q;
   assign champion_o   = champion_q;

endmodule
